// File: rtl/avalon_timer_pkg.sv
// Shared definitions for the Avalon-MM timer slave: register word offsets,
// CONTROL/STATUS bit positions, the register-index enum and small helpers
// used by the register file logic.
package avalon_timer_pkg;

   // Word offsets of the register map
   localparam int unsigned OFFSET_CONTROL  = 0;
   localparam int unsigned OFFSET_STATUS   = 1;
   localparam int unsigned OFFSET_COUNT    = 2;
   localparam int unsigned OFFSET_RELOAD   = 3;
   localparam int unsigned OFFSET_PRESCALE = 4;

   // CONTROL bit positions
   localparam int CTRL_ENABLE_BIT      = 0;
   localparam int CTRL_IRQ_EN_BIT      = 1;
   localparam int CTRL_AUTO_RELOAD_BIT = 2;
   localparam int CTRL_WIDTH           = 3;

   // STATUS bit positions
   localparam int STATUS_EXPIRED_BIT = 0;

   // Decoded register selector; REG_NONE covers every unmapped address
   typedef enum logic [2:0] {
      REG_CONTROL  = 3'd0,
      REG_STATUS   = 3'd1,
      REG_COUNT    = 3'd2,
      REG_RELOAD   = 3'd3,
      REG_PRESCALE = 3'd4,
      REG_NONE     = 3'd7
   } reg_index_e;

   // Map a word address onto the register it selects
   function automatic reg_index_e decode_address(input int unsigned word_address);
      case (word_address)
         OFFSET_CONTROL:  return REG_CONTROL;
         OFFSET_STATUS:   return REG_STATUS;
         OFFSET_COUNT:    return REG_COUNT;
         OFFSET_RELOAD:   return REG_RELOAD;
         OFFSET_PRESCALE: return REG_PRESCALE;
         default:         return REG_NONE;
      endcase
   endfunction

   // True when the byte lane carrying data bit bit_index is enabled
   function automatic logic lane_enabled(input logic [3:0] byte_en, input int bit_index);
      return byte_en[2'(bit_index >> 3)];
   endfunction

endpackage

// File: rtl/avalon_timer_slave_if.sv
// Avalon-MM slave port bundle for the timer. The master modport is the bus
// side (testbench or interconnect); the slave modport is the timer itself.
interface avalon_timer_slave_if #(
   parameter int ADDR_WIDTH = 3
);

   logic [ADDR_WIDTH-1:0] avs_s0_address;
   logic [3:0]            avs_s0_byteenable;
   logic                  avs_s0_read;
   logic [31:0]           avs_s0_readdata;
   logic                  avs_s0_readdatavalid;
   logic                  avs_s0_write;
   logic [31:0]           avs_s0_writedata;
   logic                  avs_s0_waitrequest;

   modport master (
      output avs_s0_address,
      output avs_s0_byteenable,
      output avs_s0_read,
      output avs_s0_write,
      output avs_s0_writedata,
      input  avs_s0_readdata,
      input  avs_s0_readdatavalid,
      input  avs_s0_waitrequest
   );

   modport slave (
      input  avs_s0_address,
      input  avs_s0_byteenable,
      input  avs_s0_read,
      input  avs_s0_write,
      input  avs_s0_writedata,
      output avs_s0_readdata,
      output avs_s0_readdatavalid,
      output avs_s0_waitrequest
   );

endinterface

// File: rtl/timer_prescaler.sv
// Tick prescaler for the timer. With AVALON_TIMER_PRESCALE_EN defined it
// divides the enabled cycles by PRESCALE+1; otherwise it is a pass-through
// and every enabled cycle is a tick. A restart forces the phase back to 0
// and suppresses the tick for that cycle.
module timer_prescaler #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   restart,
   input  logic [COUNT_WIDTH-1:0] prescale,
   output logic                   tick
);

`ifdef AVALON_TIMER_PRESCALE_EN

   logic [COUNT_WIDTH-1:0] phase_q;
   logic [COUNT_WIDTH-1:0] phase_d;
   logic                   last_phase;

   // Advance the phase on enabled cycles and emit a tick on the last one
   always_comb begin
      phase_d    = phase_q;
      tick       = 1'b0;
      last_phase = (phase_q >= prescale);
      if (restart) begin
         phase_d = '0;
      end else if (enable) begin
         if (last_phase) begin
            tick    = 1'b1;
            phase_d = '0;
         end else begin
            phase_d = phase_q + COUNT_WIDTH'(1);
         end
      end
   end

   // Phase register, cleared by the synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

`else

   logic unused_prescale;

   assign unused_prescale = &{1'b0, clock, reset, restart, prescale};
   assign tick            = enable;

`endif

endmodule

// File: rtl/avalon_timer_slave.sv
// Avalon-MM down-counting timer slave with interrupt. Registers: CONTROL,
// STATUS, COUNT, RELOAD and (optionally) PRESCALE. Reads have a fixed one
// cycle latency and are never stalled outside reset. Defining
// AVALON_TIMER_PRESCALE_EN adds the PRESCALE register and tick divider.
module avalon_timer_slave
   import avalon_timer_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int ADDR_WIDTH  = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   avalon_timer_slave_if.slave  avs,
   output logic                 irq
);

   logic [ADDR_WIDTH-1:0]  address;
   reg_index_e             sel;
   logic                   write_accept;
   logic                   read_accept;
   logic                   count_write;
   logic                   prescale_restart;
   logic [COUNT_WIDTH-1:0] prescale_value;
   logic                   tick;
   logic                   expire;

   logic [CTRL_WIDTH-1:0]  control_q;
   logic [CTRL_WIDTH-1:0]  control_d;
   logic                   expired_q;
   logic                   expired_d;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;
   logic [COUNT_WIDTH-1:0] reload_q;
   logic [COUNT_WIDTH-1:0] reload_d;
`ifdef AVALON_TIMER_PRESCALE_EN
   logic [COUNT_WIDTH-1:0] prescale_q;
   logic [COUNT_WIDTH-1:0] prescale_d;
`endif
   logic [31:0]            readdata_q;
   logic [31:0]            readdata_d;
   logic                   readdatavalid_q;
   logic                   readdatavalid_d;
   logic                   irq_q;
   logic                   irq_d;

   assign address = avs.avs_s0_address;
   assign sel     = decode_address(32'(address));

   // A simultaneous read and write is treated as a write only
   assign write_accept = avs.avs_s0_write;
   assign read_accept  = avs.avs_s0_read & ~avs.avs_s0_write;
   assign count_write  = write_accept && (sel == REG_COUNT);

   // Any write to COUNT or PRESCALE realigns the prescaler phase
   assign prescale_restart = write_accept && ((sel == REG_COUNT) || (sel == REG_PRESCALE));

`ifdef AVALON_TIMER_PRESCALE_EN
   assign prescale_value = prescale_q;
`else
   assign prescale_value = '0;
`endif

   timer_prescaler #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_prescaler (
      .clock    (clock),
      .reset    (reset),
      .enable   (control_q[CTRL_ENABLE_BIT]),
      .restart  (prescale_restart),
      .prescale (prescale_value),
      .tick     (tick)
   );

   // Timer countdown and register writes; a bus write to COUNT beats the
   // tick, bus writes to CONTROL lanes beat the one-shot enable clear, and a
   // fresh expiry beats a STATUS clear
   always_comb begin
      control_d = control_q;
      expired_d = expired_q;
      count_d   = count_q;
      reload_d  = reload_q;
`ifdef AVALON_TIMER_PRESCALE_EN
      prescale_d = prescale_q;
`endif
      expire    = 1'b0;

      if (tick && !count_write) begin
         if (count_q != '0) begin
            count_d = count_q - COUNT_WIDTH'(1);
         end else begin
            expire = 1'b1;
            if (control_q[CTRL_AUTO_RELOAD_BIT]) begin
               count_d = reload_q;
            end else begin
               control_d[CTRL_ENABLE_BIT] = 1'b0;
            end
         end
      end

      if (write_accept) begin
         case (sel)
            REG_CONTROL: begin
               for (int b = 0; b < CTRL_WIDTH; b++) begin
                  if (lane_enabled(avs.avs_s0_byteenable, b)) begin
                     control_d[b] = avs.avs_s0_writedata[b];
                  end
               end
            end
            REG_STATUS: begin
               if (lane_enabled(avs.avs_s0_byteenable, STATUS_EXPIRED_BIT) &&
                   avs.avs_s0_writedata[STATUS_EXPIRED_BIT]) begin
                  expired_d = 1'b0;
               end
            end
            REG_COUNT: begin
               for (int b = 0; b < COUNT_WIDTH; b++) begin
                  if (lane_enabled(avs.avs_s0_byteenable, b)) begin
                     count_d[b] = avs.avs_s0_writedata[b];
                  end
               end
            end
            REG_RELOAD: begin
               for (int b = 0; b < COUNT_WIDTH; b++) begin
                  if (lane_enabled(avs.avs_s0_byteenable, b)) begin
                     reload_d[b] = avs.avs_s0_writedata[b];
                  end
               end
            end
`ifdef AVALON_TIMER_PRESCALE_EN
            REG_PRESCALE: begin
               for (int b = 0; b < COUNT_WIDTH; b++) begin
                  if (lane_enabled(avs.avs_s0_byteenable, b)) begin
                     prescale_d[b] = avs.avs_s0_writedata[b];
                  end
               end
            end
`endif
            default: begin
            end
         endcase
      end

      if (expire) begin
         expired_d = 1'b1;
      end
   end

   // Read path: sample the addressed register now, present it next cycle
   always_comb begin
      readdata_d      = '0;
      readdatavalid_d = read_accept;
      if (read_accept) begin
         case (sel)
            REG_CONTROL:  readdata_d[CTRL_WIDTH-1:0]     = control_q;
            REG_STATUS:   readdata_d[STATUS_EXPIRED_BIT] = expired_q;
            REG_COUNT:    readdata_d[COUNT_WIDTH-1:0]    = count_q;
            REG_RELOAD:   readdata_d[COUNT_WIDTH-1:0]    = reload_q;
`ifdef AVALON_TIMER_PRESCALE_EN
            REG_PRESCALE: readdata_d[COUNT_WIDTH-1:0]    = prescale_q;
`endif
            default:      readdata_d = '0;
         endcase
      end
   end

   // Interrupt is the registered AND of the expired flag and its enable
   always_comb begin
      irq_d = expired_q & control_q[CTRL_IRQ_EN_BIT];
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         control_q       <= '0;
         expired_q       <= 1'b0;
         count_q         <= '0;
         reload_q        <= '0;
`ifdef AVALON_TIMER_PRESCALE_EN
         prescale_q      <= '0;
`endif
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         irq_q           <= 1'b0;
      end else begin
         control_q       <= control_d;
         expired_q       <= expired_d;
         count_q         <= count_d;
         reload_q        <= reload_d;
`ifdef AVALON_TIMER_PRESCALE_EN
         prescale_q      <= prescale_d;
`endif
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         irq_q           <= irq_d;
      end
   end

   // A read accepted just before reset must not surface while reset is low
   assign avs.avs_s0_waitrequest   = ~reset;
   assign avs.avs_s0_readdatavalid = readdatavalid_q & reset;
   assign avs.avs_s0_readdata      = reset ? readdata_q : 32'h0;
   assign irq                      = irq_q;

endmodule

// File: doc/avalon_timer_slave.md
AVALON_TIMER_SLAVE -- requirements
Module: avalon_timer_slave

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, width of the COUNT, RELOAD and PRESCALE registers (1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, word-address width of the slave port.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port avs_s0_address  input  ADDR_WIDTH  word address.
REQ-006 SHALL have port avs_s0_byteenable  input  4  write byte lanes.
REQ-007 SHALL have port avs_s0_read  input  1  read request.
REQ-008 SHALL have port avs_s0_readdata  output  32  read data.
REQ-009 SHALL have port avs_s0_readdatavalid  output  1  read data qualifier.
REQ-010 SHALL have port avs_s0_write  input  1  write request.
REQ-011 SHALL have port avs_s0_writedata  input  32  write data.
REQ-012 SHALL have port avs_s0_waitrequest  output  1  stall.
REQ-013 SHALL have port irq  output  1  active-high interrupt, suitable for a core's inr_irq input.

Function
REQ-014 SHALL use the register map 0 CONTROL{bit0 enable, bit1 irq_en, bit2 auto_reload}, 1 STATUS{bit0 expired}, 2 COUNT, 3 RELOAD, 4 PRESCALE; all other addresses read 0, and writes to them are ignored.
REQ-015 SHALL drive waitrequest 0 whenever reset is high, so every request is accepted in the cycle it is presented.
REQ-016 SHALL have fixed read latency 1: a read accepted in cycle N gives readdatavalid=1 in N+1 only, with readdata holding the register value sampled in cycle N; back-to-back reads are pipelined, one per cycle.
REQ-017 SHALL drive readdata 0 whenever readdatavalid=0.
REQ-018 SHALL update only byte lanes with byteenable set on a write; bits above COUNT_WIDTH are ignored on write and read as 0.
REQ-019 SHALL clear STATUS.expired when 1 is written to bit0 with byteenable[0]=1 (write-1-to-clear); writing 0 has no effect.
REQ-020 SHALL treat read and write asserted together as a write only, with no readdatavalid for that cycle.
REQ-021 SHALL generate a tick every cycle in which enable=1 (prescaled per REQ-030).
REQ-022 SHALL act on each tick as follows: if COUNT!=0, COUNT<=COUNT-1; if COUNT==0, set expired and then either COUNT<=RELOAD (auto_reload=1) or clear enable with COUNT kept at 0 (auto_reload=0).
REQ-023 SHALL give an expiry period of RELOAD+1 ticks; RELOAD=0 expires on every tick.
REQ-024 SHALL let a bus write to COUNT in the same cycle as a tick win: the written value is loaded, and no decrement or expiry occurs that cycle.
REQ-025 SHALL let a new expiry in the same cycle as a STATUS clear win, leaving expired=1.
REQ-026 SHALL drive irq registered as expired AND irq_en, one cycle after either operand changes.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, clear CONTROL, STATUS, COUNT, RELOAD, PRESCALE, the prescale counter, readdata, readdatavalid and irq.
REQ-028 SHALL drive waitrequest 1 while reset=0.
REQ-029 SHALL discard any read accepted in the cycle before reset asserts, with no readdatavalid after reset.

Configuration
REQ-030 SHALL, with AVALON_TIMER_PRESCALE_EN defined, implement PRESCALE: an internal counter emits a tick once every PRESCALE+1 enabled cycles, and the counter restarts at 0 on any write to PRESCALE or COUNT.
REQ-031 SHALL, without AVALON_TIMER_PRESCALE_EN, omit the PRESCALE register and counter, read address 4 as 0, ignore writes to it, and tick every enabled cycle.

Structure
REQ-032 SHALL place register offsets, CONTROL/STATUS bit positions and a register-index enum in a shared package avalon_timer_pkg.
REQ-033 SHALL keep the prescale counter as the single sub-module timer_prescaler; all other logic SHALL be flat.

Verification
REQ-034 SHALL cover reset: hold reset=0 for 3 cycles -> waitrequest=1, irq=0, readdatavalid=0; after release, reads of addresses 0..4 all return 0.
REQ-035 SHALL cover read pipelining: write RELOAD=0x1234, then read addresses 3,3,5 on consecutive cycles -> readdatavalid high for 3 cycles with data 0x1234, 0x1234, 0.
REQ-036 SHALL cover auto-reload: COUNT=4, RELOAD=4, write CONTROL=0x7 -> expired and irq rise after exactly 5 ticks, then every 5 ticks after a W1C clear of STATUS.
REQ-037 SHALL cover one-shot: COUNT=2, CONTROL=0x3 -> expiry after 3 ticks, CONTROL reads 0x2, COUNT stays 0, irq stays 1 until STATUS is written 0x1.
REQ-038 SHALL cover collisions: a COUNT=7 write on the expiry tick -> no expiry and COUNT reads 7; a STATUS W1C on an expiry tick -> expired remains 1.
REQ-039 SHALL cover byte enables: COUNT=0xAABBCCDD, then write 0x11223344 with byteenable=0b0101 -> COUNT reads 0xAA22CC44 (enable=0).
